// File: rtl/gcd_ip_top.sv
`default_nettype none
// ============================================================================
// Module   : gcd_ip_top
// Function : Subtractive-Euclid GCD core, one subtraction per clock.
// Revision : 1.0
// ============================================================================
module gcd_ip_top #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] cout
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] cout_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_LOAD;
            x_q     <= '0;
            y_q     <= '0;
            cout_q  <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    x_q     <= a;
                    y_q     <= b;
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    // Zero checks come first so gcd(n,0) and gcd(0,0) terminate.
                    if (y_q == '0) begin
                        cout_q  <= x_q;
                        state_q <= S_DONE;
                    end else if (x_q == '0) begin
                        cout_q  <= y_q;
                        state_q <= S_DONE;
                    end else if (x_q == y_q) begin
                        cout_q  <= x_q;
                        state_q <= S_DONE;
                    end else if (x_q > y_q) begin
                        x_q <= x_q - y_q;
                    end else begin
                        y_q <= y_q - x_q;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_ip_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_ip_top
// Function : Directed-vector bench for gcd_ip_top.
// Revision : 1.0
// ============================================================================
module tb_gcd_ip_top;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] cout;

    int n_checks;
    int n_errors;

    gcd_ip_top #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Two reset edges, then release with operands; cout checked one edge
    // before the expected result edge, on it, and after a hold interval.
    task automatic run_case(input string tag, input logic [WIDTH-1:0] op_a,
                            input logic [WIDTH-1:0] op_b,
                            input logic [WIDTH-1:0] exp, input int exp_edge);
        rst = 1'b0;
        a   = 8'hA5;
        b   = 8'h5A;
        step(2);
        check_eq({tag, "_rst"}, cout, 8'd0);
        a   = op_a;
        b   = op_b;
        rst = 1'b1;
        step(exp_edge - 1);
        check_eq({tag, "_pre"}, cout, 8'd0);
        step(1);
        check_eq({tag, "_res"}, cout, exp);
        step(6);
        check_eq({tag, "_hold"}, cout, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        a   = '0;
        b   = '0;
        step(2);
        check_eq("reset_cout", cout, 8'd0);
        check_eq("reset_state", 8'(dut.state_q), 8'd0);

        run_case("g48_18", 8'd48, 8'd18, 8'd6, 6);
        a = 8'd99;
        b = 8'd33;
        step(10);
        check_eq("ignore_ab", cout, 8'd6);
        rst = 1'b0;
        step(1);
        check_eq("rst_in_done", cout, 8'd0);

        run_case("g56_98", 8'd56, 8'd98, 8'd14, 6);
        run_case("g60_45", 8'd60, 8'd45, 8'd15, 5);
        run_case("g18_48", 8'd18, 8'd48, 8'd6, 6);
        run_case("g0_37", 8'd0, 8'd37, 8'd37, 2);
        run_case("g37_0", 8'd37, 8'd0, 8'd37, 2);
        run_case("g0_0", 8'd0, 8'd0, 8'd0, 2);
        check_eq("g0_0_state", 8'(dut.state_q), 8'd2);
        run_case("g255_1", 8'd255, 8'd1, 8'd1, 256);
        run_case("g200_200", 8'd200, 8'd200, 8'd200, 2);
        run_case("g255_255", 8'd255, 8'd255, 8'd255, 2);

        rst = 1'b0;
        step(2);
        a   = 8'd255;
        b   = 8'd1;
        rst = 1'b1;
        step(20);
        check_eq("mid_calc", cout, 8'd0);
        rst = 1'b0;
        a   = 8'd12;
        b   = 8'd8;
        step(1);
        check_eq("mid_rst_cout", cout, 8'd0);
        check_eq("mid_rst_state", 8'(dut.state_q), 8'd0);
        run_case("g12_8", 8'd12, 8'd8, 8'd4, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
